mips_mc_ctrl: RTL and testbench
===============================

# mips_mc_ctrl

Multicycle MIPS control unit: the instruction-decoding side of the 4-bit ALU control interface (F[3] = invert B and carry-in, F[2:0] = op select). It sequences every instruction through a Moore FSM, driving datapath mux selects, write enables and the ALU `F` code, and consumes the ALU `Zero` flag for branches. It sits between the instruction register and the multicycle datapath (PC, memory, register file, ALU).

## Interface
- No parameters.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: instruction[31:26], valid from the DECODE cycle onward (IR-held).
- `funct` in 6: instruction[5:0], same validity as `op`.
- `zero` in 1: ALU `Zero` flag, sampled in BRANCH.
- `pcen` out 1: PC register enable.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `memwrite` out 1: data memory write strobe.
- `irwrite` out 1: instruction register load.
- `regdst` out 1: destination select (0 = rt, 1 = rd).
- `memtoreg` out 1: writeback select (0 = ALUOut, 1 = Data).
- `regwrite` out 1: register file write enable.
- `alusrca` out 1: ALU A (0 = PC, 1 = rs).
- `alusrcb` out 2: ALU B (00 = rt, 01 = 4, 10 = SignImm, 11 = SignImm<<2).
- `pcsrc` out 2: next PC (00 = ALU result, 01 = ALUOut, 10 = jump target).
- `alucontrol` out 4: ALU `F` code.
- `illegal` out 1: one-cycle pulse on unsupported opcode/funct.
- `instret` out 32: count of retired instructions.

## Operation
- F codes: ADD 0100, SUB 1100, AND 0000, OR 0010, SLT 1110, SLL 0111, SRL 0101, SRA 0011, LUI 0001.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, IMMEX, IMMWB, JUMP.
- Unlisted outputs are 0 in every state; alucontrol defaults to ADD.
- FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, ADD, pcsrc=00, pcen=1. Next: DECODE.
- DECODE: alusrca=0, alusrcb=11, ADD (branch target into ALUOut). Next by `op`:
  - 100011 lw, 101011 sw -> MEMADR
  - 000000 R-type -> EXECUTE
  - 000100 beq, 000101 bne -> BRANCH
  - 001000 addi, 001101 ori, 001010 slti, 001111 lui -> IMMEX
  - 000010 j -> JUMP
  - otherwise: illegal=1, -> FETCH.
- MEMADR: alusrca=1, alusrcb=10, ADD. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1 -> MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1 -> FETCH.
- EXECUTE: alusrca=1, alusrcb=00, F by funct:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 000000 SLL, 000010 SRL, 000011 SRA.
  - Decoded funct -> ALUWB. Unknown funct: illegal=1, -> FETCH (no writeback).
- ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01. pcen = zero for beq, ~zero for bne. -> FETCH.
- IMMEX: alusrca=1, alusrcb=10. F: addi ADD, ori OR, slti SLT, lui LUI. -> IMMWB.
- IMMWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JUMP: pcsrc=10, pcen=1 -> FETCH.
- `instret`: +1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, IMMWB or JUMP. Not incremented on illegal exits. Wraps 0xFFFFFFFF -> 0.

## Timing
- Outputs decode combinationally from the registered state; `pcen` in BRANCH is additionally combinational on `zero`.
- Cycles per instruction:
  - lw 5; sw 4; R-type 4; addi/ori/slti/lui 4; beq/bne 3; j 3.
  - Illegal opcode: 2. Illegal funct: 3.
- Reset: on any rising edge with reset=1, state <= FETCH and instret <= 0.
  - While reset=1, all enables (pcen, irwrite, memwrite, regwrite) and `illegal` are forced 0; other outputs read as the FETCH values.
  - Reset mid-instruction abandons it with no further writes.
- First FETCH cycle is the first cycle after reset deasserts.
- `illegal` is high for exactly the one cycle spent in the detecting state (DECODE or EXECUTE).

## Test plan
- Reset, then op=100011 held: states FETCH, DECODE, MEMADR, MEMRD, MEMWB. memtoreg=1 and regwrite=1 only in cycle 5; instret 0 -> 1 entering the next FETCH.
- R-type sweep: all 8 funct codes -> EXECUTE alucontrol 0100, 1100, 0000, 0010, 1110, 0111, 0101, 0011; regdst=1 in ALUWB; 4 cycles each.
- beq, zero=1 -> pcen=1 with pcsrc=01 in BRANCH. beq, zero=0 -> pcen=0. bne inverts both cases. instret increments in all four.
- lui (001111) -> IMMEX alucontrol=0001. ori -> 0010. slti -> 1110. regwrite=1 with regdst=0 in IMMWB.
- op=111111 -> illegal=1 in DECODE, back to FETCH next cycle, instret unchanged. R-type with funct=111111 -> illegal=1 in EXECUTE, regwrite never asserted.
- Assert reset during MEMWR of a sw -> memwrite=0 from that cycle onward, FETCH after reset drops, instret=0. Preload instret=0xFFFFFFFF via 2^32-1 retires (or force) -> wraps to 0.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute and
// driving datapath selects, write enables, the ALU F code and a retire counter.
module mips_mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pcen,
    output logic        iord,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [3:0]  alucontrol,
    output logic        illegal,
    output logic [31:0] instret
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_IMMEX, S_IMMWB, S_JUMP
    } state_t;

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RTYPE = 6'b000000,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_ORI = 6'b001101, OP_SLTI = 6'b001010, OP_LUI = 6'b001111,
                           OP_J = 6'b000010;

    localparam logic [3:0] F_ADD = 4'b0100, F_SUB = 4'b1100, F_AND = 4'b0000,
                           F_OR = 4'b0010, F_SLT = 4'b1110, F_SLL = 4'b0111,
                           F_SRL = 4'b0101, F_SRA = 4'b0011, F_LUI = 4'b0001;

    // Returns {recognised, F code} for an R-type funct field.
    function automatic logic [4:0] rtype_decode(input logic [5:0] fn);
        case (fn)
            6'b100000: return {1'b1, F_ADD};
            6'b100010: return {1'b1, F_SUB};
            6'b100100: return {1'b1, F_AND};
            6'b100101: return {1'b1, F_OR};
            6'b101010: return {1'b1, F_SLT};
            6'b000000: return {1'b1, F_SLL};
            6'b000010: return {1'b1, F_SRL};
            6'b000011: return {1'b1, F_SRA};
            default:   return {1'b0, F_ADD};
        endcase
    endfunction

    state_t      state_q, state_d, cur;
    logic [31:0] instret_q, instret_d;
    logic [4:0]  rt_dec;
    logic        retire;

    assign rt_dec  = rtype_decode(funct);
    assign instret = instret_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_RTYPE:                         state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_ADDI, OP_ORI, OP_SLTI, OP_LUI: state_d = S_IMMEX;
                    OP_J:                             state_d = S_JUMP;
                    default:                          state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = rt_dec[4] ? S_ALUWB : S_FETCH;
            S_IMMEX:   state_d = S_IMMWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Only completing states retire; illegal exits from DECODE/EXECUTE do not.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: retire = 1'b1;
            default: retire = 1'b0;
        endcase
        instret_d = retire ? instret_q + 32'd1 : instret_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // While reset is held the outputs show FETCH with every write suppressed,
    // so an interrupted instruction cannot complete a store or writeback.
    always_comb begin
        cur        = reset ? S_FETCH : state_q;
        pcen       = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = F_ADD;
        illegal    = 1'b0;
        case (cur)
            S_FETCH: begin
                irwrite = 1'b1;
                alusrcb = 2'b01;
                pcen    = 1'b1;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE,
                    OP_ADDI, OP_ORI, OP_SLTI, OP_LUI, OP_J: illegal = 1'b0;
                    default:                                illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = rt_dec[3:0];
                illegal    = ~rt_dec[4];
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = F_SUB;
                pcsrc      = 2'b01;
                pcen       = (op == OP_BNE) ? ~zero : zero;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    OP_ORI:  alucontrol = F_OR;
                    OP_SLTI: alucontrol = F_SLT;
                    OP_LUI:  alucontrol = F_LUI;
                    default: alucontrol = F_ADD;
                endcase
            end
            S_IMMWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
    end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class cycle by cycle
// against hand-written output vectors and retire counts.
module tb_mips_mc_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, funct;
    logic        zero;
    logic        pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal;
    logic [1:0]  alusrcb, pcsrc;
    logic [3:0]  alucontrol;
    logic [31:0] instret;
    logic [16:0] outs;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_ret = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .illegal(illegal), .instret(instret)
    );

    // Vector order: pcen iord memwrite irwrite regdst memtoreg regwrite alusrca
    //               alusrcb[1:0] pcsrc[1:0] alucontrol[3:0] illegal
    assign outs = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                   alusrcb, pcsrc, alucontrol, illegal};

    localparam logic [16:0] E_FETCH  = {8'b1001_0000, 2'b01, 2'b00, 4'b0100, 1'b0};
    localparam logic [16:0] E_RST    = {8'b0000_0000, 2'b01, 2'b00, 4'b0100, 1'b0};
    localparam logic [16:0] E_DECODE = {8'b0000_0000, 2'b11, 2'b00, 4'b0100, 1'b0};
    localparam logic [16:0] E_DEC_IL = {8'b0000_0000, 2'b11, 2'b00, 4'b0100, 1'b1};
    localparam logic [16:0] E_MEMADR = {8'b0000_0001, 2'b10, 2'b00, 4'b0100, 1'b0};
    localparam logic [16:0] E_MEMRD  = {8'b0100_0000, 2'b00, 2'b00, 4'b0100, 1'b0};
    localparam logic [16:0] E_MEMWB  = {8'b0000_0110, 2'b00, 2'b00, 4'b0100, 1'b0};
    localparam logic [16:0] E_MEMWR  = {8'b0110_0000, 2'b00, 2'b00, 4'b0100, 1'b0};
    localparam logic [16:0] E_ALUWB  = {8'b0000_1010, 2'b00, 2'b00, 4'b0100, 1'b0};
    localparam logic [16:0] E_IMMWB  = {8'b0000_0010, 2'b00, 2'b00, 4'b0100, 1'b0};
    localparam logic [16:0] E_JUMP   = {8'b1000_0000, 2'b00, 2'b10, 4'b0100, 1'b0};

    function automatic logic [16:0] ex_v(input logic [3:0] f, input logic il);
        return {8'b0000_0001, 2'b00, 2'b00, f, il};
    endfunction

    function automatic logic [16:0] imm_v(input logic [3:0] f);
        return {8'b0000_0001, 2'b10, 2'b00, f, 1'b0};
    endfunction

    function automatic logic [16:0] br_v(input logic p);
        return {p, 7'b000_0001, 2'b00, 2'b01, 4'b1100, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Check the current cycle's outputs, then advance to the next negedge.
    task automatic cyc(input string tag, input logic [16:0] e);
        #1;
        check(tag, {15'd0, outs}, {15'd0, e});
        @(negedge clk);
    endtask

    task automatic fetch_chk(input string tag);
        #1;
        check({tag, "_ret"}, instret, exp_ret);
        cyc({tag, "_fetch"}, E_FETCH);
    endtask

    logic [5:0] r_fn [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b101010, 6'b000000, 6'b000010, 6'b000011};
    logic [3:0] r_f  [8] = '{4'b0100, 4'b1100, 4'b0000, 4'b0010,
                             4'b1110, 4'b0111, 4'b0101, 4'b0011};
    logic [5:0] i_op [4] = '{6'b001000, 6'b001101, 6'b001010, 6'b001111};
    logic [3:0] i_f  [4] = '{4'b0100, 4'b0010, 4'b1110, 4'b0001};

    initial begin
        reset = 1'b1; op = 6'b100011; funct = 6'b000000; zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check("rst_ret", instret, 32'd0);
        cyc("rst_outs", E_RST);
        reset = 1'b0;

        // lw: 5 cycles, retires on entry to the following FETCH
        fetch_chk("lw");
        cyc("lw_decode", E_DECODE);
        cyc("lw_memadr", E_MEMADR);
        cyc("lw_memrd", E_MEMRD);
        #1 check("lw_ret_pre", instret, 32'd0);
        cyc("lw_memwb", E_MEMWB);
        exp_ret++;

        op = 6'b101011;
        fetch_chk("sw");
        cyc("sw_decode", E_DECODE);
        cyc("sw_memadr", E_MEMADR);
        cyc("sw_memwr", E_MEMWR);
        exp_ret++;

        op = 6'b000000;
        for (int i = 0; i < 8; i++) begin
            funct = r_fn[i];
            fetch_chk($sformatf("r%0d", i));
            cyc($sformatf("r%0d_decode", i), E_DECODE);
            cyc($sformatf("r%0d_exec", i), ex_v(r_f[i], 1'b0));
            cyc($sformatf("r%0d_aluwb", i), E_ALUWB);
            exp_ret++;
        end

        for (int i = 0; i < 4; i++) begin
            op   = (i < 2) ? 6'b000100 : 6'b000101;
            zero = i[0];
            fetch_chk($sformatf("br%0d", i));
            cyc($sformatf("br%0d_decode", i), E_DECODE);
            cyc($sformatf("br%0d_branch", i), br_v((i < 2) ? zero : ~zero));
            exp_ret++;
        end
        zero = 1'b0;

        for (int i = 0; i < 4; i++) begin
            op = i_op[i];
            fetch_chk($sformatf("imm%0d", i));
            cyc($sformatf("imm%0d_decode", i), E_DECODE);
            cyc($sformatf("imm%0d_immex", i), imm_v(i_f[i]));
            cyc($sformatf("imm%0d_immwb", i), E_IMMWB);
            exp_ret++;
        end

        op = 6'b000010;
        fetch_chk("j");
        cyc("j_decode", E_DECODE);
        cyc("j_jump", E_JUMP);
        exp_ret++;

        // illegal opcode: 2 cycles, no retire
        op = 6'b111111;
        fetch_chk("ilop");
        cyc("ilop_decode", E_DEC_IL);

        // illegal funct: 3 cycles, no writeback, no retire
        op = 6'b000000; funct = 6'b111111;
        fetch_chk("ilfn");
        cyc("ilfn_decode", E_DECODE);
        cyc("ilfn_exec", ex_v(4'b0100, 1'b1));
        fetch_chk("ilfn_after");
        cyc("ilfn_after_decode", E_DECODE);
        cyc("ilfn_after_exec", ex_v(4'b0100, 1'b1));

        // reset during MEMWR of a sw
        op = 6'b101011; funct = 6'b000000;
        fetch_chk("swr");
        cyc("swr_decode", E_DECODE);
        cyc("swr_memadr", E_MEMADR);
        reset = 1'b1;
        cyc("swr_rst_memwr", E_RST);
        cyc("swr_rst_hold", E_RST);
        reset = 1'b0;
        exp_ret = 0;
        fetch_chk("swr_after");
        cyc("swr_after_decode", E_DECODE);
        cyc("swr_after_memadr", E_MEMADR);
        cyc("swr_after_memwr", E_MEMWR);
        exp_ret++;

        // retire counter wrap: preload all-ones, then retire a jump
        op = 6'b000010;
        fetch_chk("wrap");
        force dut.instret_q = 32'hFFFF_FFFF;
        #1 release dut.instret_q;
        #1 check("wrap_pre", instret, 32'hFFFF_FFFF);
        cyc("wrap_decode", E_DECODE);
        cyc("wrap_jump", E_JUMP);
        exp_ret = 32'd0;
        fetch_chk("wrap_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
